// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Function : UART transmitter, 6/7/8-bit character, LSB first, one stop bit,
//            parity state inserted when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx #(
   parameter int TICKS_PER_BIT = 16,
   parameter int PARITY_ODD    = 0
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       TxEn,
   input  logic       TxStart,
   input  logic [7:0] TxData,
   input  logic [3:0] NBits,
   input  logic       Tick,
   output logic       Tx,
   output logic       TxBusy,
   output logic       TxDone
);

   localparam int c_CW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [c_CW-1:0] c_TICK_LAST = c_CW'(TICKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            r_state,    w_state;
   logic [c_CW-1:0]   r_tick_cnt, w_tick_cnt;
   logic [2:0]        r_bit_idx,  w_bit_idx;
   logic [2:0]        r_last_idx, w_last_idx;
   logic [7:0]        r_data,     w_data;
   logic              r_tx,       w_tx;
   logic              r_busy,     w_busy;
   logic              r_done,     w_done;
   logic              w_bit_end;
   logic [2:0]        w_nbits_last;

   // Unsupported lengths fall back to 8 bits.
   assign w_nbits_last = (NBits == 4'd6) ? 3'd5 :
                         (NBits == 4'd7) ? 3'd6 : 3'd7;

   assign w_bit_end = Tick && (r_tick_cnt == c_TICK_LAST);

`ifdef UART_TX_PARITY_EN
   localparam logic c_ODD = (PARITY_ODD != 0);
   logic [7:0] w_mask;
   logic       w_parity;
   assign w_mask   = 8'hFF >> (3'd7 - r_last_idx);
   assign w_parity = (^(r_data & w_mask)) ^ c_ODD;
`else
   logic w_unused_parity_odd;
   assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

   always_comb begin
      w_state    = r_state;
      w_tick_cnt = r_tick_cnt;
      w_bit_idx  = r_bit_idx;
      w_last_idx = r_last_idx;
      w_data     = r_data;
      w_tx       = r_tx;
      w_busy     = r_busy;
      w_done     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx   = 1'b1;
            w_busy = 1'b0;
            if (TxEn && TxStart) begin
               w_data     = TxData;
               w_last_idx = w_nbits_last;
               w_state    = S_START;
               w_tx       = 1'b0;
               w_busy     = 1'b1;
               w_tick_cnt = '0;
               w_bit_idx  = 3'd0;
            end
         end
         default: begin
            if (Tick) begin
               w_tick_cnt = r_tick_cnt + c_CW'(1);
            end
            if (w_bit_end) begin
               w_tick_cnt = '0;
               case (r_state)
                  S_START: begin
                     w_state = S_DATA;
                     w_tx    = r_data[0];
                  end
                  S_DATA: begin
                     if (r_bit_idx == r_last_idx) begin
`ifdef UART_TX_PARITY_EN
                        w_state = S_PARITY;
                        w_tx    = w_parity;
`else
                        w_state = S_STOP;
                        w_tx    = 1'b1;
`endif
                     end else begin
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_tx      = r_data[w_bit_idx];
                     end
                  end
`ifdef UART_TX_PARITY_EN
                  S_PARITY: begin
                     w_state = S_STOP;
                     w_tx    = 1'b1;
                  end
`endif
                  S_STOP: begin
                     w_state = S_IDLE;
                     w_tx    = 1'b1;
                     w_busy  = 1'b0;
                     w_done  = 1'b1;
                  end
                  default: begin
                     w_state = S_IDLE;
                     w_tx    = 1'b1;
                     w_busy  = 1'b0;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
         r_bit_idx  <= 3'd0;
         r_last_idx <= 3'd0;
         r_data     <= 8'd0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_tick_cnt <= w_tick_cnt;
         r_bit_idx  <= w_bit_idx;
         r_last_idx <= w_last_idx;
         r_data     <= w_data;
         r_tx       <= w_tx;
         r_busy     <= w_busy;
         r_done     <= w_done;
      end
   end

   assign Tx     = r_tx;
   assign TxBusy = r_busy;
   assign TxDone = r_done;

endmodule

`default_nettype wire
